// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: byte width and default FIFO sizing.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int DEFAULT_DEPTH    = 16;
    localparam int DEFAULT_AF_LEVEL = 12;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bus between the UART receiver, the receive FIFO and its consumer.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);

    logic                     i_Rx_DV;
    logic [UART_DATA_W-1:0]   i_Rx_Byte;
    logic                     o_Valid;
    logic [UART_DATA_W-1:0]   o_Data;
    logic                     i_Ready;
    logic [$clog2(DEPTH):0]   o_Count;
    logic                     o_Almost_Full;
    logic                     o_Overflow;
    logic                     i_Clear_Ovf;

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Ready, i_Clear_Ovf,
        output o_Valid, o_Data, o_Count, o_Almost_Full, o_Overflow
    );

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Ready, i_Clear_Ovf,
        input  o_Valid, o_Data, o_Count, o_Almost_Full, o_Overflow
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     i_Clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with a sticky overrun flag, so the
// serial line is never back-pressured by a slow consumer.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEFAULT_AF_LEVEL
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    uart_rx_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a byte.
    assign full = (count == CW'(DEPTH));
    assign pop  = (count != '0) && bus.i_Ready;
    assign push = bus.i_Rx_DV && (!full || pop);
    assign drop = bus.i_Rx_DV && full && !pop;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (UART_DATA_W)
    ) u_mem (
        .i_Clock (i_Clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.i_Rx_Byte),
        .rd_addr (rd_ptr),
        .rd_data (bus.o_Data)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new overrun outranks a clear arriving in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.i_Clear_Ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.o_Valid       = (count != '0);
    assign bus.o_Count       = count;
    assign bus.o_Almost_Full = (count >= CW'(AF_LEVEL));
    assign bus.o_Overflow    = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int D4   = 4;
    localparam int AF4  = 3;
    localparam int D16  = 16;
    localparam int AF16 = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(D4))  bus4 ();
    uart_rx_fifo_if #(.DEPTH(D16)) bus16 ();

    uart_rx_fifo #(.DEPTH(D4), .AF_LEVEL(AF4)) u_dut4 (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus4)
    );

    uart_rx_fifo #(.DEPTH(D16), .AF_LEVEL(AF16)) u_dut16 (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q4[$];
    bit         ovf4;

    typedef struct {
        logic       dv;
        logic [7:0] b;
        logic       rdy;
        logic       clr;
        int         cnt;
        logic [7:0] data;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a byte queue plus a sticky bit, applied once per clock edge.
    task automatic model_step(input logic dv, input logic [7:0] b, input logic rdy, input logic clr);
        bit was_full;
        bit popped;
        bit set_ovf;
        was_full = (q4.size() == D4);
        popped   = (q4.size() != 0) && rdy;
        set_ovf  = 1'b0;
        if (popped) void'(q4.pop_front());
        if (dv) begin
            if (!was_full || popped) q4.push_back(b);
            else set_ovf = 1'b1;
        end
        if (set_ovf) ovf4 = 1'b1;
        else if (clr) ovf4 = 1'b0;
    endtask

    task automatic step4(input logic dv, input logic [7:0] b, input logic rdy, input logic clr);
        bus4.i_Rx_DV     = dv;
        bus4.i_Rx_Byte   = b;
        bus4.i_Ready     = rdy;
        bus4.i_Clear_Ovf = clr;
        @(posedge clk);
        model_step(dv, b, rdy, clr);
        #1;
        bus4.i_Rx_DV     = 1'b0;
        bus4.i_Ready     = 1'b0;
        bus4.i_Clear_Ovf = 1'b0;
    endtask

    task automatic step16(input logic dv, input logic [7:0] b, input logic clr);
        bus16.i_Rx_DV     = dv;
        bus16.i_Rx_Byte   = b;
        bus16.i_Clear_Ovf = clr;
        @(posedge clk);
        #1;
        bus16.i_Rx_DV     = 1'b0;
        bus16.i_Clear_Ovf = 1'b0;
    endtask

    task automatic check4(input string tag);
        chk({tag, " valid"}, 32'(bus4.o_Valid), 32'(q4.size() != 0));
        chk({tag, " count"}, 32'(bus4.o_Count), 32'(q4.size()));
        chk({tag, " af"}, 32'(bus4.o_Almost_Full), 32'(q4.size() >= AF4));
        chk({tag, " ovf"}, 32'(bus4.o_Overflow), 32'(ovf4));
        if (q4.size() != 0) chk({tag, " data"}, 32'(bus4.o_Data), 32'(q4[0]));
    endtask

    task automatic add(input logic dv, input logic [7:0] b, input logic rdy, input logic clr,
                       input int cnt, input logic [7:0] data, input logic ovf);
        tbl.push_back('{dv, b, rdy, clr, cnt, data, ovf});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus4.i_Rx_DV = 1'b0;  bus4.i_Rx_Byte = '0;  bus4.i_Ready = 1'b0;  bus4.i_Clear_Ovf = 1'b0;
        bus16.i_Rx_DV = 1'b0; bus16.i_Rx_Byte = '0; bus16.i_Ready = 1'b0; bus16.i_Clear_Ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid4", 32'(bus4.o_Valid), 0);
        chk("reset count4", 32'(bus4.o_Count), 0);
        chk("reset af4", 32'(bus4.o_Almost_Full), 0);
        chk("reset ovf4", 32'(bus4.o_Overflow), 0);
        chk("reset count16", 32'(bus16.o_Count), 0);
        rst = 1'b0;
        q4.delete();
        ovf4 = 1'b0;

        // Single byte in and out.
        step4(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("single valid", 32'(bus4.o_Valid), 1);
        chk("single data", 32'(bus4.o_Data), 32'h A5);
        chk("single count", 32'(bus4.o_Count), 1);
        step4(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single pop valid", 32'(bus4.o_Valid), 0);
        chk("single pop count", 32'(bus4.o_Count), 0);

        // Ordering and wrap
        add(1,8'h01,0,0, 1,8'h01,0); add(1,8'h02,0,0, 2,8'h01,0);
        add(1,8'h03,0,0, 3,8'h01,0); add(1,8'h04,0,0, 4,8'h01,0);
        add(0,8'h00,1,0, 3,8'h02,0); add(0,8'h00,1,0, 2,8'h03,0);
        add(1,8'h05,0,0, 3,8'h03,0); add(1,8'h06,0,0, 4,8'h03,0);
        add(0,8'h00,1,0, 3,8'h04,0); add(0,8'h00,1,0, 2,8'h05,0);
        add(0,8'h00,1,0, 1,8'h06,0); add(0,8'h00,1,0, 0,8'h00,0);
        // Overflow: 0x14 dropped, then cleared and drained
        add(1,8'h10,0,0, 1,8'h10,0); add(1,8'h11,0,0, 2,8'h10,0);
        add(1,8'h12,0,0, 3,8'h10,0); add(1,8'h13,0,0, 4,8'h10,0);
        add(1,8'h14,0,0, 4,8'h10,1); add(0,8'h00,0,1, 4,8'h10,0);
        add(0,8'h00,1,0, 3,8'h11,0); add(0,8'h00,1,0, 2,8'h12,0);
        add(0,8'h00,1,0, 1,8'h13,0); add(0,8'h00,1,0, 0,8'h00,0);
        // Full with simultaneous push and pop
        add(1,8'h20,0,0, 1,8'h20,0); add(1,8'h21,0,0, 2,8'h20,0);
        add(1,8'h22,0,0, 3,8'h20,0); add(1,8'h23,0,0, 4,8'h20,0);
        add(1,8'h24,1,0, 4,8'h21,0); add(0,8'h00,1,0, 3,8'h22,0);
        add(0,8'h00,1,0, 2,8'h23,0); add(0,8'h00,1,0, 1,8'h24,0);
        add(0,8'h00,1,0, 0,8'h00,0);
        // Empty with ready: no pop; push into empty with ready held high
        add(0,8'h00,1,0, 0,8'h00,0); add(1,8'h77,1,0, 1,8'h77,0);
        add(1,8'h78,1,0, 1,8'h78,0); add(0,8'h00,1,0, 0,8'h00,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step4(tbl[i].dv, tbl[i].b, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d count", i), 32'(bus4.o_Count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d valid", i), 32'(bus4.o_Valid), 32'(tbl[i].cnt != 0));
            chk($sformatf("vec%0d af", i), 32'(bus4.o_Almost_Full), 32'(tbl[i].cnt >= AF4));
            chk($sformatf("vec%0d ovf", i), 32'(bus4.o_Overflow), 32'(tbl[i].ovf));
            if (tbl[i].cnt != 0) chk($sformatf("vec%0d data", i), 32'(bus4.o_Data), 32'(tbl[i].data));
        end

        for (int i = 0; i < 400; i++) begin
            step4(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0));
            check4($sformatf("rnd%0d", i));
        end

        // Asynchronous reset with bytes stored and overrun pending.
        for (int i = 0; i < 5; i++) step4(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        chk("pre-reset ovf", 32'(bus4.o_Overflow), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset valid", 32'(bus4.o_Valid), 0);
        chk("async reset count", 32'(bus4.o_Count), 0);
        chk("async reset ovf", 32'(bus4.o_Overflow), 0);
        bus4.i_Rx_DV   = 1'b1;
        bus4.i_Rx_Byte = 8'hEE;
        @(posedge clk);
        #1;
        bus4.i_Rx_DV = 1'b0;
        rst = 1'b0;
        q4.delete();
        ovf4 = 1'b0;
        chk("reset strobe lost", 32'(bus4.o_Count), 0);
        step4(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("post-reset data", 32'(bus4.o_Data), 32'h5A);
        chk("post-reset count", 32'(bus4.o_Count), 1);
        check4("post-reset");

        // Almost-full threshold and set-over-clear priority on the deep FIFO.
        for (int i = 0; i < 11; i++) step16(1'b1, 8'(i), 1'b0);
        chk("af16 at 11", 32'(bus16.o_Almost_Full), 0);
        chk("count16 at 11", 32'(bus16.o_Count), 11);
        step16(1'b1, 8'd11, 1'b0);
        chk("af16 at 12", 32'(bus16.o_Almost_Full), 1);
        for (int i = 12; i < 16; i++) step16(1'b1, 8'(i), 1'b0);
        chk("count16 full", 32'(bus16.o_Count), 16);
        chk("ovf16 at full", 32'(bus16.o_Overflow), 0);
        step16(1'b1, 8'hFF, 1'b1);
        chk("ovf16 set beats clear", 32'(bus16.o_Overflow), 1);
        chk("count16 after drop", 32'(bus16.o_Count), 16);
        chk("head16 after drop", 32'(bus16.o_Data), 0);
        step16(1'b0, 8'h00, 1'b1);
        chk("ovf16 cleared", 32'(bus16.o_Overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
